// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the parametrised register file.
//   - clr_state_e : state of the sequential clear engine
//   - DEF_DATA_W  : default register width
//   - DEF_NUM_REGS: default register count
// -----------------------------------------------------------------------------
package regfile_pkg;

  typedef enum logic {
    CLR_IDLE   = 1'b0,
    CLR_ACTIVE = 1'b1
  } clr_state_e;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 4;

endpackage

// File: rtl/regfile_clr_seq.sv
// -----------------------------------------------------------------------------
// regfile_clr_seq
// Sequential clear engine: walks a pointer over every register, one per cycle,
// and tells the array to write zero there.
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset (aborts a clear in progress)
//   i_clr_req    level request; sampled only while idle, ignored while clearing
//   o_clr_busy   high exactly while the engine is in CLR_ACTIVE
//   o_clr_we     zero-write strobe for the array
//   o_clr_addr   register being zeroed this cycle
//   o_state      current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr_req,
  output logic              o_clr_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr,
  output clr_state_e        o_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  clr_state_e        r_state;
  clr_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= CLR_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      CLR_IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = CLR_ACTIVE;
          w_ptr_nxt   = '0;
        end
      end
      CLR_ACTIVE: begin
        // NUM_REGS is a power of two, so the increment wraps back to 0 on the
        // same edge that leaves CLR_ACTIVE.
        w_ptr_nxt = r_ptr + 1'b1;
        if (r_ptr == LAST_ADDR) begin
          w_state_nxt = CLR_IDLE;
        end
      end
      default: begin
        w_state_nxt = CLR_IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  assign o_clr_busy = (r_state == CLR_ACTIVE);
  assign o_clr_we   = (r_state == CLR_ACTIVE);
  assign o_clr_addr = r_ptr;
  assign o_state    = r_state;

endmodule

// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
// Parametrised register file with optional hardwired-zero r0, optional
// write-to-read bypass, a per-register pending scoreboard and a sequential
// clear engine.
// Ports:
//   clk, rst                     clock / synchronous active-high reset
//   write_enable, rd_addr,       writeback port (accepted only when idle)
//   rd_data
//   rs1_addr/rs1_data,           read ports, combinational, optional bypass
//   rs2_addr/rs2_data
//   rs1_pending, rs2_pending     registered pending bits of the read addresses
//   reserve_en, reserve_addr     mark a register as pending
//   clr_req, clr_busy            start / status of the sequential clear
//   dbg_addr, dbg_data           debug read port, never bypassed
// Interface note: there is no valid/ready handshake here. write_enable and
// reserve_en are single-cycle strobes acted on at the edge when the clear
// engine is idle and dropped otherwise; clr_req is a level request taken only
// while idle; clr_busy reports the clear window.
// -----------------------------------------------------------------------------
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rs1_pending,
  output logic              rs2_pending,
  input  logic              reserve_en,
  input  logic [ADDR_W-1:0] reserve_addr,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_pend;

  logic              w_clr_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  clr_state_e        w_clr_state;
  logic              w_idle;
  logic              w_wr_ok;
  logic              w_rsv_ok;
  logic              w_rs1_zero;
  logic              w_rs2_zero;
  logic              w_dbg_zero;

  regfile_clr_seq #(
    .NUM_REGS (NUM_REGS)
  ) u_clr_seq (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clr_req  (clr_req),
    .o_clr_busy (w_clr_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr),
    .o_state    (w_clr_state)
  );

  assign w_idle = (w_clr_state == CLR_IDLE);

  // Writes and reservations are only honoured while idle; r0 is excluded when
  // it is hardwired to zero.
  assign w_wr_ok  = write_enable && w_idle && !((ZERO_REG != 0) && (rd_addr == '0));
  assign w_rsv_ok = reserve_en && w_idle && !((ZERO_REG != 0) && (reserve_addr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_pend <= '0;
    end else if (w_clr_we) begin
      r_regs[w_clr_addr] <= '0;
      r_pend[w_clr_addr] <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_regs[rd_addr] <= rd_data;
        r_pend[rd_addr] <= 1'b0;
      end
      // Placed after the write so a same-cycle reserve of the same register
      // leaves the bit set.
      if (w_rsv_ok) begin
        r_pend[reserve_addr] <= 1'b1;
      end
    end
  end

  assign w_rs1_zero = (ZERO_REG != 0) && (rs1_addr == '0);
  assign w_rs2_zero = (ZERO_REG != 0) && (rs2_addr == '0);
  assign w_dbg_zero = (ZERO_REG != 0) && (dbg_addr == '0);

  always_comb begin
    rs1_data = r_regs[rs1_addr];
    if (w_rs1_zero) begin
      rs1_data = '0;
    end else if ((BYPASS != 0) && w_wr_ok && (rd_addr == rs1_addr)) begin
      rs1_data = rd_data;
    end
  end

  always_comb begin
    rs2_data = r_regs[rs2_addr];
    if (w_rs2_zero) begin
      rs2_data = '0;
    end else if ((BYPASS != 0) && w_wr_ok && (rd_addr == rs2_addr)) begin
      rs2_data = rd_data;
    end
  end

  assign dbg_data    = w_dbg_zero ? '0 : r_regs[dbg_addr];
  assign rs1_pending = r_pend[rs1_addr];
  assign rs2_pending = r_pend[rs2_addr];
  assign clr_busy    = w_clr_busy;

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised successor to the team's 4x16 register file: configurable width and depth, optional hardwired-zero r0, and write-to-read bypass. Adds a per-register pending scoreboard for multi-cycle producers and a sequential clear engine that zeroes the array one entry per cycle. Sits between decode (read ports), writeback (write port) and the debug/LED path (debug read port).

Parameters:
DATA_W, 16, register width in bits
NUM_REGS, 4, number of registers, power of two, >= 2
ZERO_REG, 1, 1 = r0 reads 0, ignores writes and is never pending
BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports
(localparam ADDR_W = $clog2(NUM_REGS))

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
write_enable  in  1  write strobe
rd_addr  in  ADDR_W  write address
rd_data  in  DATA_W  write data
rs1_addr  in  ADDR_W  read port 1 address
rs2_addr  in  ADDR_W  read port 2 address
rs1_data  out  DATA_W  read port 1 data, combinational
rs2_data  out  DATA_W  read port 2 data, combinational
rs1_pending  out  1  pending bit of rs1_addr, combinational
rs2_pending  out  1  pending bit of rs2_addr, combinational
reserve_en  in  1  mark reserve_addr as pending
reserve_addr  in  ADDR_W  register being reserved
clr_req  in  1  start sequential clear
clr_busy  out  1  clear engine active
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  DATA_W  debug read data, combinational, no bypass

Behaviour:
- Reset (rst=1 at clk edge): all registers 0, all pending bits 0, FSM IDLE, clear pointer 0; clr_busy=0 the following cycle. rst overrides every other input.
- Write: in IDLE, write_enable=1 writes rd_data to regs[rd_addr] at the edge; 1-cycle write latency. With ZERO_REG=1, writes to address 0 are dropped.
- Read: rsN_data = regs[rsN_addr]; address 0 with ZERO_REG=1 returns 0.
- Bypass: with BYPASS=1, if write_enable, IDLE, rd_addr==rsN_addr and the write is not dropped, then rsN_data=rd_data in the same cycle. With BYPASS=0, the old value is returned until the edge.
- Scoreboard: reserve_en sets pending[reserve_addr]; an accepted write clears pending[rd_addr].
  - Reserve and write to the same address in the same cycle: the reservation wins, so the bit ends at 1.
  - Reserve of r0 with ZERO_REG=1 is ignored.
  - The pending outputs do not bypass: they reflect the registered bits.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clr_req=1; pointer is 0.
  - In CLEAR, each cycle writes 0 to regs[ptr] and clears pending[ptr], then increments ptr.
  - CLEAR -> IDLE on the edge where ptr == NUM_REGS-1; ptr wraps to 0.
  - A full clear takes exactly NUM_REGS cycles. clr_busy=1 exactly while in CLEAR.
  - While in CLEAR: write_enable, reserve_en and clr_req are ignored (not queued). Reads still return current array contents, including partially cleared state.
  - clr_req held high in IDLE restarts a clear on the cycle after CLEAR finishes.
- Reset mid-clear: the FSM aborts to IDLE and the whole array is zeroed by the reset itself.
- Address width: all addresses are exactly ADDR_W bits, so there is no out-of-range case.

Decomposition:
- Package regfile_pkg holds the clear FSM state typedef (CLR_IDLE, CLR_ACTIVE) and the default DATA_W/NUM_REGS constants.
- One sub-module, regfile_clr_seq, holds the FSM and pointer. It outputs clr_busy, clr_we and clr_addr. The array, scoreboard and bypass muxing stay in regfile_param.

Test Plan:
- Defaults, after rst: write 16'hBEEF to r2, then read rs1=2 next cycle -> rs1_data=16'hBEEF; a later write of 16'h1234 to r0 leaves rs2_data at addr 0 = 16'h0000.
- Bypass: in the same cycle, write r3=16'hA5A5 and set rs1_addr=3 -> rs1_data=16'hA5A5 with BYPASS=1, and the prior value with BYPASS=0; dbg_data at addr 3 shows the prior value in both cases.
- Scoreboard: reserve r1 -> rs1_pending=1 next cycle; write r1=16'h0042 -> pending=0 next cycle; reserve and write r1 in the same cycle -> pending=1.
- Clear, NUM_REGS=8: fill r1..r7 with nonzero values and reserve r5, pulse clr_req -> clr_busy high for exactly 8 cycles. During that window a write of 16'hFFFF to r4 is ignored. Afterwards all regs read 0 and all pending bits are 0.
- Reset mid-clear: assert rst in the 3rd cycle of CLEAR -> next cycle clr_busy=0, all regs 0, and a new write succeeds immediately.
- Width/depth, DATA_W=32 and NUM_REGS=16: write 32'hDEADBEEF to r15 -> reads back intact; a reserve of r0 is ignored.
